// File: rtl/axi_window_pkg.sv
// rtl/axi_window_pkg.sv - response codes and error FSM states for the AXI address window
package axi_window_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SINK = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ERR  = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_mem_window_if.sv
// rtl/axi_mem_window_if.sv - AXI4 channel bundle with master/slave views
interface axi_mem_window_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 6
);
    localparam int STRB_W = DATA_W / 8;

    logic              aw_valid, aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [ID_W-1:0]   aw_id;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              aw_lock;
    logic [3:0]        aw_cache;
    logic [2:0]        aw_prot;
    logic [3:0]        aw_qos;

    logic              ar_valid, ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [ID_W-1:0]   ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_lock;
    logic [3:0]        ar_cache;
    logic [2:0]        ar_prot;
    logic [3:0]        ar_qos;

    logic              w_valid, w_ready, w_last;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;

    logic              b_valid, b_ready;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;

    logic              r_valid, r_ready, r_last;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
        input  aw_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
        input  ar_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
        output aw_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
        output ar_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready
    );

endinterface

// File: rtl/axi_window_err_slave.sv
// rtl/axi_window_err_slave.sv - local DECERR terminator for out-of-window bursts
module axi_window_err_slave
    import axi_window_pkg::*;
#(
    parameter int ID_W = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            aw_miss,
    input  logic [ID_W-1:0] aw_id,
    input  logic            w_beat,
    input  logic            w_last,
    input  logic            b_hs,
    input  logic            ar_miss,
    input  logic [ID_W-1:0] ar_id,
    input  logic [7:0]      ar_len,
    input  logic            r_hs,
    output logic            w_idle,
    output logic            w_sink,
    output logic            b_valid,
    output logic [ID_W-1:0] b_id,
    output logic            r_idle,
    output logic            r_valid,
    output logic            r_last,
    output logic [ID_W-1:0] r_id
);

    w_state_e   w_state;
    r_state_e   r_state;
    logic [7:0] beats;

    // Write side: swallow the data beats of a missed burst, then answer with one DECERR.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_state <= W_IDLE;
            b_id    <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_miss) begin
                    w_state <= W_SINK;
                    b_id    <= aw_id;
                end
                W_SINK: if (w_beat && w_last) w_state <= W_RESP;
                W_RESP: if (b_hs) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read side: emit len+1 zero-data DECERR beats, counting down to the last one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            beats   <= '0;
        end else if (r_state == R_IDLE) begin
            if (ar_miss) begin
                r_state <= R_ERR;
                r_id    <= ar_id;
                beats   <= ar_len;
            end
        end else if (r_hs) begin
            if (beats == 8'd0) r_state <= R_IDLE;
            else               beats   <= beats - 8'd1;
        end
    end

    assign w_idle  = (w_state == W_IDLE);
    assign w_sink  = (w_state == W_SINK);
    assign b_valid = (w_state == W_RESP);
    assign r_idle  = (r_state == R_IDLE);
    assign r_valid = (r_state == R_ERR);
    assign r_last  = (beats == 8'd0);

endmodule

// File: rtl/axi_mem_window.sv
// rtl/axi_mem_window.sv - AXI4 address-window bridge with local DECERR for misses
module axi_mem_window
    import axi_window_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 64,
    parameter int                ID_W            = 6,
    parameter int                WIN_BITS        = 28,
    parameter logic [ADDR_W-1:0] IN_BASE         = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] OUT_BASE        = 32'h1000_0000,
    parameter int                MAX_OUTSTANDING = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    axi_mem_window_if.slave     s,
    axi_mem_window_if.master    m,
    output logic [15:0]         decerr_cnt,
    output logic [ADDR_W-1:0]   decerr_addr
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic             aw_hit, ar_hit, aw_fwd_ok, ar_fwd_ok, aw_miss_ok, ar_miss_ok;
    logic             aw_miss_acc, ar_miss_acc, w_beat, b_err_hs, r_err_hs;
    logic             wr_inc, wr_dec, rd_inc, rd_dec;
    logic             w_idle, w_sink, err_b_valid, r_idle, err_r_valid, err_r_last;
    logic [ID_W-1:0]  err_b_id, err_r_id;
    logic [1:0]       miss_inc;
    logic [16:0]      decerr_sum;

    assign aw_hit = (s.aw_addr[ADDR_W-1:WIN_BITS] == IN_BASE[ADDR_W-1:WIN_BITS]);
    assign ar_hit = (s.ar_addr[ADDR_W-1:WIN_BITS] == IN_BASE[ADDR_W-1:WIN_BITS]);

    // A miss waits for an empty pipe so its error response cannot overtake forwarded ones.
    assign aw_fwd_ok  = reset_n && w_idle && (wr_cnt < CNT_MAX);
    assign ar_fwd_ok  = reset_n && r_idle && (rd_cnt < CNT_MAX);
    assign aw_miss_ok = reset_n && w_idle && (wr_cnt == '0);
    assign ar_miss_ok = reset_n && r_idle && (rd_cnt == '0);

    assign m.aw_valid = s.aw_valid && aw_hit && aw_fwd_ok;
    assign s.aw_ready = aw_hit ? (aw_fwd_ok && m.aw_ready) : aw_miss_ok;
    assign m.aw_addr  = {OUT_BASE[ADDR_W-1:WIN_BITS], s.aw_addr[WIN_BITS-1:0]};
    assign m.aw_id    = s.aw_id;
    assign m.aw_len   = s.aw_len;
    assign m.aw_size  = s.aw_size;
    assign m.aw_burst = s.aw_burst;
    assign m.aw_lock  = s.aw_lock;
    assign m.aw_cache = s.aw_cache;
    assign m.aw_prot  = s.aw_prot;
    assign m.aw_qos   = s.aw_qos;

    assign m.ar_valid = s.ar_valid && ar_hit && ar_fwd_ok;
    assign s.ar_ready = ar_hit ? (ar_fwd_ok && m.ar_ready) : ar_miss_ok;
    assign m.ar_addr  = {OUT_BASE[ADDR_W-1:WIN_BITS], s.ar_addr[WIN_BITS-1:0]};
    assign m.ar_id    = s.ar_id;
    assign m.ar_len   = s.ar_len;
    assign m.ar_size  = s.ar_size;
    assign m.ar_burst = s.ar_burst;
    assign m.ar_lock  = s.ar_lock;
    assign m.ar_cache = s.ar_cache;
    assign m.ar_prot  = s.ar_prot;
    assign m.ar_qos   = s.ar_qos;

    assign m.w_valid = reset_n && s.w_valid && !w_sink;
    assign s.w_ready = reset_n && (w_sink || m.w_ready);
    assign m.w_data  = s.w_data;
    assign m.w_strb  = s.w_strb;
    assign m.w_last  = s.w_last;

    assign s.b_valid = reset_n && (w_idle ? m.b_valid : err_b_valid);
    assign s.b_id    = w_idle ? m.b_id : err_b_id;
    assign s.b_resp  = w_idle ? m.b_resp : RESP_DECERR;
    assign m.b_ready = reset_n && w_idle && s.b_ready;

    assign s.r_valid = reset_n && (r_idle ? m.r_valid : err_r_valid);
    assign s.r_id    = r_idle ? m.r_id : err_r_id;
    assign s.r_data  = r_idle ? m.r_data : {DATA_W{1'b0}};
    assign s.r_resp  = r_idle ? m.r_resp : RESP_DECERR;
    assign s.r_last  = r_idle ? m.r_last : err_r_last;
    assign m.r_ready = reset_n && r_idle && s.r_ready;

    assign aw_miss_acc = s.aw_valid && s.aw_ready && !aw_hit;
    assign ar_miss_acc = s.ar_valid && s.ar_ready && !ar_hit;
    assign w_beat      = w_sink && s.w_valid && s.w_ready;
    assign b_err_hs    = !w_idle && s.b_valid && s.b_ready;
    assign r_err_hs    = !r_idle && s.r_valid && s.r_ready;

    assign wr_inc = m.aw_valid && m.aw_ready;
    assign wr_dec = m.b_valid && m.b_ready;
    assign rd_inc = m.ar_valid && m.ar_ready;
    assign rd_dec = m.r_valid && m.r_ready && m.r_last;

    // Outstanding forwarded writes: one per AW, retired by its B.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               wr_cnt <= '0;
        else if (wr_inc && !wr_dec) wr_cnt <= wr_cnt + CNT_ONE;
        else if (!wr_inc && wr_dec) wr_cnt <= wr_cnt - CNT_ONE;
    end

    // Outstanding forwarded reads: one per AR, retired by its final R beat.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)               rd_cnt <= '0;
        else if (rd_inc && !rd_dec) rd_cnt <= rd_cnt + CNT_ONE;
        else if (!rd_inc && rd_dec) rd_cnt <= rd_cnt - CNT_ONE;
    end

    assign miss_inc   = {1'b0, aw_miss_acc} + {1'b0, ar_miss_acc};
    assign decerr_sum = {1'b0, decerr_cnt} + {15'd0, miss_inc};

    // Debug: saturating miss count and the last missed address (AR wins a tie).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            decerr_cnt  <= '0;
            decerr_addr <= '0;
        end else begin
            decerr_cnt <= decerr_sum[16] ? 16'hFFFF : decerr_sum[15:0];
            if (ar_miss_acc)      decerr_addr <= s.ar_addr;
            else if (aw_miss_acc) decerr_addr <= s.aw_addr;
        end
    end

    axi_window_err_slave #(.ID_W(ID_W)) u_err (
        .clock   (clock),
        .reset_n (reset_n),
        .aw_miss (aw_miss_acc),
        .aw_id   (s.aw_id),
        .w_beat  (w_beat),
        .w_last  (s.w_last),
        .b_hs    (b_err_hs),
        .ar_miss (ar_miss_acc),
        .ar_id   (s.ar_id),
        .ar_len  (s.ar_len),
        .r_hs    (r_err_hs),
        .w_idle  (w_idle),
        .w_sink  (w_sink),
        .b_valid (err_b_valid),
        .b_id    (err_b_id),
        .r_idle  (r_idle),
        .r_valid (err_r_valid),
        .r_last  (err_r_last),
        .r_id    (err_r_id)
    );

endmodule

// File: tb/tb_axi_mem_window.sv
// tb/tb_axi_mem_window.sv - randomized self-checking bench for axi_mem_window
module tb_axi_mem_window;
    import axi_window_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 64;
    localparam int          ID_W     = 6;
    localparam int          WIN_BITS = 28;
    localparam logic [31:0] IN_BASE  = 32'h8000_0000;
    localparam logic [31:0] OUT_BASE = 32'h1000_0000;
    localparam logic [31:0] WIN      = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] decerr_cnt;
    logic [31:0] decerr_addr;
    int          checks = 0;
    int          errors = 0;
    int          exp_decerr = 0;
    logic [31:0] exp_daddr = '0;

    always #5 clock = ~clock;

    axi_mem_window_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_if ();
    axi_mem_window_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_if ();

    axi_mem_window #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .WIN_BITS(WIN_BITS),
        .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .MAX_OUTSTANDING(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .s(s_if), .m(m_if),
        .decerr_cnt(decerr_cnt), .decerr_addr(decerr_addr)
    );

    function automatic bit is_hit(logic [31:0] a);
        return (a / WIN) == (IN_BASE / WIN);
    endfunction

    function automatic logic [31:0] remap(logic [31:0] a);
        return (OUT_BASE - (OUT_BASE % WIN)) + (a % WIN);
    endfunction

    function automatic logic [31:0] hit_addr();
        return IN_BASE + ($urandom % WIN);
    endfunction

    function automatic logic [31:0] miss_addr();
        logic [31:0] a;
        do a = $urandom; while (is_hit(a));
        return a;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        s_if.aw_valid = 0; s_if.aw_addr = '0; s_if.aw_id = '0; s_if.aw_len = '0; s_if.aw_size = 3'd3;
        s_if.aw_burst = 2'd1; s_if.aw_lock = 0; s_if.aw_cache = '0; s_if.aw_prot = '0; s_if.aw_qos = '0;
        s_if.ar_valid = 0; s_if.ar_addr = '0; s_if.ar_id = '0; s_if.ar_len = '0; s_if.ar_size = 3'd3;
        s_if.ar_burst = 2'd1; s_if.ar_lock = 0; s_if.ar_cache = '0; s_if.ar_prot = '0; s_if.ar_qos = '0;
        s_if.w_valid = 0; s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = 0;
        s_if.b_ready = 0; s_if.r_ready = 0;
        m_if.aw_ready = 0; m_if.ar_ready = 0; m_if.w_ready = 0;
        m_if.b_valid = 0; m_if.b_id = '0; m_if.b_resp = RESP_OKAY;
        m_if.r_valid = 0; m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = RESP_OKAY; m_if.r_last = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        s_if.aw_valid = 1; s_if.aw_addr = 32'h0000_0040; s_if.ar_valid = 1; s_if.ar_addr = IN_BASE;
        s_if.w_valid = 1; s_if.b_ready = 1; s_if.r_ready = 1;
        m_if.aw_ready = 1; m_if.ar_ready = 1; m_if.w_ready = 1; m_if.b_valid = 1; m_if.r_valid = 1;
        step(); step();
        checks++;
        if ({s_if.aw_ready, s_if.ar_ready, s_if.w_ready, s_if.b_valid, s_if.r_valid} !== 5'b0) begin
            errors++; $display("FAIL reset_up: got %b want 00000", {s_if.aw_ready, s_if.ar_ready, s_if.w_ready, s_if.b_valid, s_if.r_valid});
        end
        checks++;
        if ({m_if.aw_valid, m_if.ar_valid, m_if.w_valid, m_if.b_ready, m_if.r_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_down: got %b want 00000", {m_if.aw_valid, m_if.ar_valid, m_if.w_valid, m_if.b_ready, m_if.r_ready});
        end
        checks++;
        if (decerr_cnt !== 16'd0 || decerr_addr !== 32'd0) begin
            errors++; $display("FAIL reset_debug: got cnt=%0d addr=%h want 0/0", decerr_cnt, decerr_addr);
        end
        idle_inputs();
        step();
        reset_n = 1;
        step();
    endtask

    task automatic test_fwd_write();
        logic [31:0] a; logic [5:0] id; logic [7:0] len; logic [3:0] qos; logic [2:0] prot;
        logic [63:0] d; bit rdy; int b; int cyc;
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 32'h8000_1000 : hit_addr();
            id = 6'($urandom); len = (t == 0) ? 8'd3 : 8'($urandom_range(0, 7));
            qos = 4'($urandom); prot = 3'($urandom);
            s_if.aw_valid = 1; s_if.aw_addr = a; s_if.aw_id = id; s_if.aw_len = len;
            s_if.aw_qos = qos; s_if.aw_prot = prot; m_if.aw_ready = 1;
            #1;
            checks++;
            if (m_if.aw_valid !== 1'b1 || s_if.aw_ready !== 1'b1 || m_if.aw_addr !== remap(a)) begin
                errors++; $display("FAIL fwd_aw: got v=%b r=%b addr=%h want 1/1/%h", m_if.aw_valid, s_if.aw_ready, m_if.aw_addr, remap(a));
            end
            checks++;
            if ({m_if.aw_id, m_if.aw_len, m_if.aw_qos, m_if.aw_prot} !== {id, len, qos, prot}) begin
                errors++; $display("FAIL fwd_aw_fields: got %h want %h", {m_if.aw_id, m_if.aw_len, m_if.aw_qos, m_if.aw_prot}, {id, len, qos, prot});
            end
            step();
            s_if.aw_valid = 0; m_if.aw_ready = 0;
            b = 0; cyc = 0;
            while (b <= int'(len) && cyc < 60) begin
                d = {$urandom, $urandom}; rdy = ($urandom_range(0, 3) != 0);
                s_if.w_valid = 1; s_if.w_data = d; s_if.w_last = (b == int'(len)); m_if.w_ready = rdy;
                #1;
                checks++;
                if (m_if.w_valid !== 1'b1 || m_if.w_data !== d || m_if.w_last !== (b == int'(len)) || s_if.w_ready !== rdy) begin
                    errors++; $display("FAIL fwd_w: got v=%b d=%h l=%b r=%b want 1/%h/%b/%b", m_if.w_valid, m_if.w_data, m_if.w_last, s_if.w_ready, d, (b == int'(len)), rdy);
                end
                step();
                if (rdy) b++;
                cyc++;
            end
            s_if.w_valid = 0; s_if.w_last = 0; m_if.w_ready = 0;
            m_if.b_valid = 1; m_if.b_id = id; m_if.b_resp = RESP_OKAY; s_if.b_ready = 1;
            #1;
            checks++;
            if (s_if.b_valid !== 1'b1 || s_if.b_id !== id || s_if.b_resp !== RESP_OKAY || m_if.b_ready !== 1'b1) begin
                errors++; $display("FAIL fwd_b: got v=%b id=%0d resp=%0d mr=%b want 1/%0d/0/1", s_if.b_valid, s_if.b_id, s_if.b_resp, m_if.b_ready, id);
            end
            step();
            idle_inputs();
        end
    endtask

    task automatic test_read_miss();
        logic [31:0] a; logic [5:0] id; int len; int beat; int cyc;
        for (int t = 0; t < 3; t++) begin
            a = (t == 0) ? 32'h4000_0000 : miss_addr();
            id = (t == 0) ? 6'd5 : 6'($urandom);
            len = (t == 0) ? 7 : $urandom_range(0, 15);
            s_if.ar_valid = 1; s_if.ar_addr = a; s_if.ar_id = id; s_if.ar_len = 8'(len); m_if.ar_ready = 1;
            #1;
            checks++;
            if (m_if.ar_valid !== 1'b0 || s_if.ar_ready !== 1'b1) begin
                errors++; $display("FAIL rmiss_accept: got mv=%b sr=%b want 0/1", m_if.ar_valid, s_if.ar_ready);
            end
            step();
            s_if.ar_valid = 0;
            exp_decerr++; exp_daddr = a;
            beat = 0; cyc = 0;
            while (beat <= len && cyc < 100) begin
                s_if.r_ready = (t == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                #1;
                checks++;
                if (s_if.r_valid !== 1'b1 || s_if.r_id !== id || s_if.r_data !== '0 || s_if.r_resp !== RESP_DECERR ||
                    s_if.r_last !== (beat == len) || m_if.ar_valid !== 1'b0) begin
                    errors++; $display("FAIL rmiss_beat%0d: got v=%b id=%0d d=%h resp=%0d last=%b want 1/%0d/0/3/%b", beat,
                        s_if.r_valid, s_if.r_id, s_if.r_data, s_if.r_resp, s_if.r_last, id, (beat == len));
                end
                step();
                if (s_if.r_ready) beat++;
                cyc++;
            end
            s_if.r_ready = 0;
            #1;
            checks++;
            if (s_if.r_valid !== 1'b0) begin
                errors++; $display("FAIL rmiss_done: got r_valid=%b want 0", s_if.r_valid);
            end
            checks++;
            if (decerr_cnt !== 16'(exp_decerr) || decerr_addr !== exp_daddr) begin
                errors++; $display("FAIL rmiss_debug: got %0d/%h want %0d/%h", decerr_cnt, decerr_addr, exp_decerr, exp_daddr);
            end
            idle_inputs();
        end
    endtask

    task automatic test_write_miss();
        logic [31:0] a; logic [5:0] id; int len;
        for (int t = 0; t < 3; t++) begin
            a = (t == 0) ? 32'h0000_0040 : miss_addr();
            id = (t == 0) ? 6'd2 : 6'($urandom);
            len = (t == 0) ? 1 : $urandom_range(0, 3);
            s_if.aw_valid = 1; s_if.aw_addr = a; s_if.aw_id = id; s_if.aw_len = 8'(len); m_if.aw_ready = 1;
            #1;
            checks++;
            if (s_if.aw_ready !== 1'b1 || m_if.aw_valid !== 1'b0) begin
                errors++; $display("FAIL wmiss_accept: got sr=%b mv=%b want 1/0", s_if.aw_ready, m_if.aw_valid);
            end
            step();
            s_if.aw_valid = 0;
            exp_decerr++; exp_daddr = a;
            for (int b = 0; b <= len; b++) begin
                s_if.w_valid = 1; s_if.w_last = (b == len); s_if.w_data = {$urandom, $urandom};
                #1;
                checks++;
                if (s_if.w_ready !== 1'b1 || m_if.w_valid !== 1'b0) begin
                    errors++; $display("FAIL wmiss_sink%0d: got sr=%b mv=%b want 1/0", b, s_if.w_ready, m_if.w_valid);
                end
                step();
            end
            s_if.w_valid = 0; s_if.w_last = 0; s_if.b_ready = 1;
            #1;
            checks++;
            if (s_if.b_valid !== 1'b1 || s_if.b_id !== id || s_if.b_resp !== RESP_DECERR || m_if.b_ready !== 1'b0) begin
                errors++; $display("FAIL wmiss_b: got v=%b id=%0d resp=%0d mr=%b want 1/%0d/3/0", s_if.b_valid, s_if.b_id, s_if.b_resp, m_if.b_ready, id);
            end
            step();
            s_if.b_ready = 0;
            #1;
            checks++;
            if (s_if.b_valid !== 1'b0 || decerr_cnt !== 16'(exp_decerr) || decerr_addr !== exp_daddr) begin
                errors++; $display("FAIL wmiss_done: got bv=%b cnt=%0d addr=%h want 0/%0d/%h", s_if.b_valid, decerr_cnt, decerr_addr, exp_decerr, exp_daddr);
            end
            idle_inputs();
        end
    endtask

    task automatic test_dual_miss();
        logic [31:0] aw_a, ar_a;
        aw_a = miss_addr(); ar_a = miss_addr();
        s_if.aw_valid = 1; s_if.aw_addr = aw_a; s_if.aw_len = 0;
        s_if.ar_valid = 1; s_if.ar_addr = ar_a; s_if.ar_len = 0;
        #1;
        checks++;
        if (s_if.aw_ready !== 1'b1 || s_if.ar_ready !== 1'b1) begin
            errors++; $display("FAIL dual_accept: got aw=%b ar=%b want 1/1", s_if.aw_ready, s_if.ar_ready);
        end
        step();
        exp_decerr += 2; exp_daddr = ar_a;
        s_if.aw_valid = 0; s_if.ar_valid = 0;
        s_if.w_valid = 1; s_if.w_last = 1; s_if.r_ready = 1;
        #1;
        checks++;
        if (s_if.r_valid !== 1'b1 || s_if.r_last !== 1'b1 || s_if.w_ready !== 1'b1) begin
            errors++; $display("FAIL dual_beats: got rv=%b rl=%b wr=%b want 1/1/1", s_if.r_valid, s_if.r_last, s_if.w_ready);
        end
        step();
        s_if.w_valid = 0; s_if.w_last = 0; s_if.r_ready = 0; s_if.b_ready = 1;
        #1;
        checks++;
        if (s_if.b_valid !== 1'b1 || s_if.b_resp !== RESP_DECERR || s_if.r_valid !== 1'b0) begin
            errors++; $display("FAIL dual_b: got bv=%b resp=%0d rv=%b want 1/3/0", s_if.b_valid, s_if.b_resp, s_if.r_valid);
        end
        checks++;
        if (decerr_cnt !== 16'(exp_decerr) || decerr_addr !== ar_a) begin
            errors++; $display("FAIL dual_debug: got %0d/%h want %0d/%h", decerr_cnt, decerr_addr, exp_decerr, ar_a);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_ordering();
        logic [31:0] a, ma; logic [5:0] mid; int mlen; int outstanding; int cyc; bit sent; bit sent_last;
        logic [63:0] qd[$]; bit ql[$]; logic [5:0] qi[$]; int len;
        for (int i = 0; i < 3; i++) begin
            a = hit_addr(); len = $urandom_range(0, 2);
            s_if.ar_valid = 1; s_if.ar_addr = a; s_if.ar_id = 6'(i + 10); s_if.ar_len = 8'(len); m_if.ar_ready = 1;
            #1;
            checks++;
            if (m_if.ar_valid !== 1'b1 || s_if.ar_ready !== 1'b1 || m_if.ar_addr !== remap(a)) begin
                errors++; $display("FAIL ord_fwd%0d: got v=%b r=%b addr=%h want 1/1/%h", i, m_if.ar_valid, s_if.ar_ready, m_if.ar_addr, remap(a));
            end
            step();
            for (int b = 0; b <= len; b++) begin
                qd.push_back({$urandom, $urandom}); ql.push_back(b == len); qi.push_back(6'(i + 10));
            end
        end
        ma = miss_addr(); mid = 6'($urandom); mlen = $urandom_range(0, 3);
        s_if.ar_valid = 1; s_if.ar_addr = ma; s_if.ar_id = mid; s_if.ar_len = 8'(mlen); s_if.r_ready = 1;
        outstanding = 3; cyc = 0;
        while (cyc < 60) begin
            sent = (qd.size() > 0);
            m_if.r_valid = sent;
            if (sent) begin
                m_if.r_data = qd[0]; m_if.r_last = ql[0]; m_if.r_id = qi[0]; m_if.r_resp = RESP_OKAY;
            end
            #1;
            checks++;
            if (s_if.ar_ready !== (outstanding == 0)) begin
                errors++; $display("FAIL ord_stall: got ar_ready=%b want %b (outstanding %0d)", s_if.ar_ready, (outstanding == 0), outstanding);
            end
            if (sent) begin
                checks++;
                if (s_if.r_valid !== 1'b1 || s_if.r_data !== qd[0] || s_if.r_id !== qi[0] || s_if.r_last !== ql[0]) begin
                    errors++; $display("FAIL ord_fwd_r: got v=%b d=%h id=%0d l=%b want 1/%h/%0d/%b", s_if.r_valid, s_if.r_data, s_if.r_id, s_if.r_last, qd[0], qi[0], ql[0]);
                end
            end
            step();
            if (outstanding == 0) break;
            if (sent) begin
                sent_last = ql[0];
                void'(qd.pop_front()); void'(ql.pop_front()); void'(qi.pop_front());
                if (sent_last) outstanding--;
            end
            cyc++;
        end
        s_if.ar_valid = 0; m_if.r_valid = 0; m_if.r_last = 0;
        exp_decerr++; exp_daddr = ma;
        for (int b = 0; b <= mlen; b++) begin
            #1;
            checks++;
            if (s_if.r_valid !== 1'b1 || s_if.r_id !== mid || s_if.r_resp !== RESP_DECERR || s_if.r_last !== (b == mlen)) begin
                errors++; $display("FAIL ord_err%0d: got v=%b id=%0d resp=%0d l=%b want 1/%0d/3/%b", b, s_if.r_valid, s_if.r_id, s_if.r_resp, s_if.r_last, mid, (b == mlen));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int stall; logic [31:0] ma;
        m_if.aw_ready = 1; s_if.b_ready = 1;
        for (int i = 0; i < 8; i++) begin
            s_if.aw_valid = 1; s_if.aw_addr = hit_addr(); s_if.aw_id = 6'($urandom);
            #1;
            checks++;
            if (s_if.aw_ready !== 1'b1 || m_if.aw_valid !== 1'b1) begin
                errors++; $display("FAIL bp_issue%0d: got r=%b v=%b want 1/1", i, s_if.aw_ready, m_if.aw_valid);
            end
            step();
        end
        s_if.aw_addr = hit_addr();
        stall = $urandom_range(1, 4);
        for (int k = 0; k < stall; k++) begin
            #1;
            checks++;
            if (s_if.aw_ready !== 1'b0 || m_if.aw_valid !== 1'b0) begin
                errors++; $display("FAIL bp_full: got r=%b v=%b want 0/0", s_if.aw_ready, m_if.aw_valid);
            end
            step();
        end
        m_if.b_valid = 1;
        #1;
        checks++;
        if (s_if.aw_ready !== 1'b0) begin
            errors++; $display("FAIL bp_b_cycle: got ar=%b want 0", s_if.aw_ready);
        end
        step();
        m_if.b_valid = 0;
        #1;
        checks++;
        if (s_if.aw_ready !== 1'b1 || m_if.aw_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release: got r=%b v=%b want 1/1", s_if.aw_ready, m_if.aw_valid);
        end
        step();
        s_if.aw_valid = 0; m_if.b_valid = 1;
        step();
        s_if.aw_valid = 1; s_if.aw_addr = hit_addr();
        #1;
        checks++;
        if (s_if.aw_ready !== 1'b1) begin
            errors++; $display("FAIL bp_simul: got r=%b want 1", s_if.aw_ready);
        end
        step();
        ma = miss_addr();
        s_if.aw_addr = ma; s_if.aw_len = 0;
        for (int k = 0; k < 7; k++) begin
            #1;
            checks++;
            if (s_if.aw_ready !== 1'b0) begin
                errors++; $display("FAIL bp_drain%0d: got miss ready=%b want 0", k, s_if.aw_ready);
            end
            step();
        end
        m_if.b_valid = 0;
        #1;
        checks++;
        if (s_if.aw_ready !== 1'b1) begin
            errors++; $display("FAIL bp_empty: got miss ready=%b want 1", s_if.aw_ready);
        end
        step();
        exp_decerr++; exp_daddr = ma;
        s_if.aw_valid = 0; s_if.w_valid = 1; s_if.w_last = 1;
        step();
        s_if.w_valid = 0; s_if.w_last = 0;
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        s_if.ar_valid = 1; s_if.ar_addr = miss_addr(); s_if.ar_len = 8'd7; s_if.ar_id = 6'($urandom);
        step();
        s_if.ar_valid = 0; s_if.r_ready = 1;
        step(); step(); step();
        reset_n = 0;
        #1;
        exp_decerr = 0; exp_daddr = '0;
        checks++;
        if (s_if.r_valid !== 1'b0 || decerr_cnt !== 16'd0 || decerr_addr !== 32'd0) begin
            errors++; $display("FAIL rst_mid: got rv=%b cnt=%0d addr=%h want 0/0/0", s_if.r_valid, decerr_cnt, decerr_addr);
        end
        step();
        reset_n = 1;
        idle_inputs();
        a = hit_addr();
        s_if.ar_valid = 1; s_if.ar_addr = a; m_if.ar_ready = 1;
        #1;
        checks++;
        if (m_if.ar_valid !== 1'b1 || s_if.ar_ready !== 1'b1 || m_if.ar_addr !== remap(a)) begin
            errors++; $display("FAIL rst_after: got v=%b r=%b addr=%h want 1/1/%h", m_if.ar_valid, s_if.ar_ready, m_if.ar_addr, remap(a));
        end
        step();
        s_if.ar_valid = 0; m_if.r_valid = 1; m_if.r_last = 1; s_if.r_ready = 1;
        #1;
        checks++;
        if (s_if.r_valid !== 1'b1 || s_if.r_resp !== RESP_OKAY || m_if.r_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after_r: got v=%b resp=%0d mr=%b want 1/0/1", s_if.r_valid, s_if.r_resp, m_if.r_ready);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fwd_write();
        test_read_miss();
        test_write_miss();
        test_dual_miss();
        test_ordering();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
